led_status_arbiter: RTL
=======================

Name: led_status_arbiter

Overview:
- Shares the board's 10 user LEDs between three status requesters: 0 = fault, 1 = debug, 2 = activity.
- Grants the display by fixed priority, with a minimum hold time, an optional blink mode and a free-running prescaler.
- Produces active-high LED bits. These feed the downstream active-low conversion stage that drives the LED pins.

Parameters:
- TICK_DIV, 25000000, clock cycles per tick (one blink half-period). Legal range is 2 or more.
- HOLD_TICKS, 2, minimum ticks a granted pattern stays displayed after its request drops. Legal range is 1 to 255.

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  asynchronous active-low reset
- i_req  input  3  per-source display request, level-sensitive; bit 0 has highest priority
- i_pattern0  input  10  LED pattern of source 0, active-high
- i_pattern1  input  10  LED pattern of source 1
- i_pattern2  input  10  LED pattern of source 2
- i_blink  input  3  per-source blink enable, sampled with the pattern
- o_grant  output  3  one-hot owner of the display; all zero when idle
- o_ledbits  output  10  registered active-high LED drive
- o_tick  output  1  one-cycle pulse at each tick

Behaviour:
- Reset: one clock, reset is asynchronous and active-low (i_reset_n). All outputs are 0. Prescaler, blink phase and hold counter are 0. State is IDLE.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - o_tick = 1 in the cycle where count == TICK_DIV-1.
  - The blink phase register toggles on each tick. After reset the phase is 0, meaning LEDs off.
- Blink rule:
  - o_ledbits = latched pattern when the latched blink bit is 0.
  - o_ledbits = latched pattern & {10{phase}} when the latched blink bit is 1.
- Winner: lowest-index asserted i_req bit.
- State IDLE:
  - o_grant = 0, o_ledbits = 0.
  - If any request is asserted, latch the winner's index, pattern and blink bit, load hold = HOLD_TICKS, and go to SHOW.
  - o_grant and o_ledbits update on that same clock edge, so LEDs follow the request with one cycle of latency.
- State SHOW:
  - The owner's pattern and blink bit are re-latched every cycle, so pattern changes appear one cycle later.
  - hold is reloaded to HOLD_TICKS every cycle.
  - If a higher-priority request asserts, it preempts immediately: the new owner is latched on the next edge with no hold wait.
  - If the owner's request drops and no higher-priority request is asserted, go to HOLD. The last pattern stays latched.
- State HOLD:
  - Pattern is frozen; o_grant still shows the previous owner.
  - hold decrements on each tick.
  - If any request with priority higher than or equal to the previous owner asserts, grant the winner and go to SHOW.
  - If hold reaches 0 on a tick: with a lower-priority request pending, grant it (load and go to SHOW); otherwise go to IDLE and clear the outputs.
- Simultaneous events:
  - Preemption and owner-drop in the same cycle: the preemption wins.
  - Tick and re-grant in the same cycle: the re-grant wins and hold reloads.
- Reset mid-operation: reset forces IDLE asynchronously with outputs 0 immediately. The prescaler restarts from 0.
- Invariant: o_grant is one-hot or zero at all times.
- Widths: hold counter is 8 bits; prescaler is $clog2(TICK_DIV) bits.

Decomposition:
- Package led_arb_pkg holds:
  - typedef enum state_t {IDLE, SHOW, HOLD};
  - constant NUM_LED_SRC = 3;
  - constant LED_WIDTH = 10;
  - typedef logic [LED_WIDTH-1:0] led_pattern_t.
- Sub-module led_tick_prescaler(TICK_DIV) holds the counter and o_tick. The blink phase and FSM stay in the top module.

Test Plan (TICK_DIV=4, HOLD_TICKS=2):
- Reset then idle: i_req=000 for 20 cycles -> o_ledbits=0, o_grant=0; o_tick pulses every 4th cycle.
- Single grant: i_req=100, i_pattern2=10'h2AA, i_blink=0 -> one cycle later o_grant=100 and o_ledbits=2AA; a pattern change to 155 appears one cycle later.
- Preemption: source 2 shown, then i_req=101 with i_pattern0=3FF -> next cycle o_grant=001 and o_ledbits=3FF, with no hold wait.
- Hold expiry: source 0 drops while i_req=100 stays asserted -> 3FF holds for 2 ticks, then o_grant=100 with o_ledbits=2AA. With i_req=000 instead, the outputs clear to 0 after 2 ticks.
- Blink: i_req=010, i_pattern1=0F0, i_blink=010 -> o_ledbits alternates 000 and 0F0, changing the cycle after each o_tick.
- Async reset mid-HOLD: i_reset_n low between clock edges -> outputs 0 immediately. After release, re-grant proceeds normally and the prescaler restarts from 0.

Source files
------------

// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED status arbiter: source count,
// LED width, FSM state encoding and a one-hot helper for the grant vector.
package led_arb_pkg;

  localparam int NUM_LED_SRC = 3;
  localparam int LED_WIDTH   = 10;

  typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

  typedef logic [LED_WIDTH-1:0] led_pattern_t;
  typedef logic [1:0]           src_idx_t;

  function automatic logic [NUM_LED_SRC-1:0] idx_to_onehot(input src_idx_t idx);
    return NUM_LED_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; o_tick marks the last count of each
// period and paces both the blink phase and the hold timer.
module led_tick_prescaler #(
  parameter int TICK_DIV = 25000000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_tick
);

  localparam int             CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (count == CNT_MAX) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign o_tick = (count == CNT_MAX);

endmodule

// File: rtl/led_status_arbiter.sv
// Fixed-priority owner of the 10 user LEDs (source 0 highest) with a
// minimum hold after the owner drops, per-source blink and a tick pulse.
module led_status_arbiter
  import led_arb_pkg::*;
#(
  parameter int TICK_DIV   = 25000000,
  parameter int HOLD_TICKS = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [NUM_LED_SRC-1:0] i_req,
  input  logic [LED_WIDTH-1:0]   i_pattern0,
  input  logic [LED_WIDTH-1:0]   i_pattern1,
  input  logic [LED_WIDTH-1:0]   i_pattern2,
  input  logic [NUM_LED_SRC-1:0] i_blink,
  output logic [NUM_LED_SRC-1:0] o_grant,
  output logic [LED_WIDTH-1:0]   o_ledbits,
  output logic                   o_tick
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);

  state_t       state, state_d;
  src_idx_t     owner, owner_d;
  led_pattern_t pat, pat_d;
  logic         blink_q, blink_d;
  logic [7:0]   hold, hold_d;
  logic         phase, phase_d;

  logic                   win_vld;
  src_idx_t               win_idx;
  logic                   load;
  src_idx_t               load_idx;
  led_pattern_t           load_pat;
  led_pattern_t           led_d;
  logic [NUM_LED_SRC-1:0] grant_d;

  led_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_tick    (o_tick)
  );

  // Lowest asserted request index wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_LED_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        win_vld = 1'b1;
        win_idx = src_idx_t'(i);
      end
    end
  end

  always_comb begin
    state_d  = state;
    owner_d  = owner;
    pat_d    = pat;
    blink_d  = blink_q;
    hold_d   = hold;
    load     = 1'b0;
    load_idx = win_idx;

    case (state)
      IDLE: begin
        load = win_vld;
      end
      SHOW: begin
        if (win_vld && (win_idx < owner)) begin
          load = 1'b1;
        end else if (i_req[owner]) begin
          load     = 1'b1;
          load_idx = owner;
        end else begin
          state_d = HOLD;
          hold_d  = HOLD_INIT;
        end
      end
      HOLD: begin
        // A re-grant takes precedence over a tick arriving in the same cycle.
        if (win_vld && (win_idx <= owner)) begin
          load = 1'b1;
        end else if (o_tick) begin
          if (hold == 8'd1) begin
            if (win_vld) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              hold_d  = '0;
            end
          end else begin
            hold_d = hold - 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase

    case (load_idx)
      2'd0:    load_pat = i_pattern0;
      2'd1:    load_pat = i_pattern1;
      default: load_pat = i_pattern2;
    endcase

    if (load) begin
      state_d = SHOW;
      owner_d = load_idx;
      pat_d   = load_pat;
      blink_d = i_blink[load_idx];
      hold_d  = HOLD_INIT;
    end
  end

  // Outputs are built from next-state values so they change on the same edge.
  always_comb begin
    phase_d = phase ^ o_tick;
    led_d   = '0;
    grant_d = '0;
    if (state_d != IDLE) begin
      led_d   = blink_d ? (pat_d & {LED_WIDTH{phase_d}}) : pat_d;
      grant_d = idx_to_onehot(owner_d);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      owner     <= '0;
      pat       <= '0;
      blink_q   <= 1'b0;
      hold      <= '0;
      phase     <= 1'b0;
      o_grant   <= '0;
      o_ledbits <= '0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      pat       <= pat_d;
      blink_q   <= blink_d;
      hold      <= hold_d;
      phase     <= phase_d;
      o_grant   <= grant_d;
      o_ledbits <= led_d;
    end
  end

endmodule
